// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 valid/ready router with a one-entry registered buffer per sink.
// Optional per-port drain counters are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t        st0;
  buf_state_t        st1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              accept;
  logic              load0;
  logic              load1;

  // A port can take a word if it is empty or is being drained this cycle.
  assign in_ready = in_sel ? ((st1 == EMPTY) | out1_ready)
                           : ((st0 == EMPTY) | out0_ready);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~in_sel;
  assign load1    = accept &  in_sel;

  assign out0_valid = (st0 == FULL);
  assign out1_valid = (st1 == FULL);
  assign out0_data  = data0;
  assign out1_data  = data1;

  // Per-port buffer: a load wins over a drain so back-to-back words stream at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      st0   <= EMPTY;
      st1   <= EMPTY;
      data0 <= '0;
      data1 <= '0;
    end else begin
      case (st0)
        EMPTY: begin
          if (load0) begin
            st0   <= FULL;
            data0 <= in_data;
          end
        end
        FULL: begin
          if (load0) begin
            data0 <= in_data;
          end else if (out0_ready) begin
            st0 <= EMPTY;
          end
        end
        default: st0 <= EMPTY;
      endcase
      case (st1)
        EMPTY: begin
          if (load1) begin
            st1   <= FULL;
            data1 <= in_data;
          end
        end
        FULL: begin
          if (load1) begin
            data1 <= in_data;
          end else if (out1_ready) begin
            st1 <= EMPTY;
          end
        end
        default: st1 <= EMPTY;
      endcase
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             drain0;
  logic             drain1;

  assign drain0 = (st0 == FULL) & out0_ready;
  assign drain1 = (st1 == FULL) & out1_ready;

  // Completed-transfer counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (drain0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (drain1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random traffic vs a queue model.
module tb_stream_demux;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Reference model: each port is a queue of words in flight plus the last word it showed.
  logic [DATA_W-1:0] mq0[$];
  logic [DATA_W-1:0] mq1[$];
  logic [DATA_W-1:0] last0 = '0;
  logic [DATA_W-1:0] last1 = '0;
  int unsigned       nd0 = 0;
  int unsigned       nd1 = 0;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int unsigned n);
`ifdef STREAM_DEMUX_CNT_EN
    return CNT_W'(n % (1 << CNT_W));
`else
    return (n == 0) ? '0 : '0;
`endif
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    check("out0_valid", 64'(out0_valid), 64'(mq0.size() != 0));
    check("out1_valid", 64'(out1_valid), 64'(mq1.size() != 0));
    check("out0_data", 64'(out0_data), 64'((mq0.size() != 0) ? mq0[0] : last0));
    check("out1_data", 64'(out1_data), 64'((mq1.size() != 0) ? mq1[0] : last1));
    check("cnt0", 64'(cnt0), 64'(exp_cnt(nd0)));
    check("cnt1", 64'(cnt1), 64'(exp_cnt(nd1)));
    exp_rdy = in_sel ? ((mq1.size() == 0) || out1_ready) : ((mq0.size() == 0) || out0_ready);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (rst) begin
      mq0.delete();
      mq1.delete();
      last0 = '0;
      last1 = '0;
      nd0 = 0;
      nd1 = 0;
    end else begin
      if ((mq0.size() != 0) && out0_ready) begin
        last0 = mq0.pop_front();
        nd0++;
      end
      if ((mq1.size() != 0) && out1_ready) begin
        last1 = mq1.pop_front();
        nd1++;
      end
      if (acc) begin
        if (in_sel) mq1.push_back(in_data);
        else        mq0.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic send(input logic sel, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    step();
  endtask

  initial begin
    // Reset held two cycles with a word offered: it must be dropped.
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hDEADBEEF;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #1;
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out0_valid", 64'(out0_valid), 64'd0);
    check("rst_out1_valid", 64'(out1_valid), 64'd0);
    check("rst_out0_data", 64'(out0_data), 64'd0);
    check("rst_out1_data", 64'(out1_data), 64'd0);
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_cnt1", 64'(cnt1), 64'd0);
    step();

    // Basic steering to both ports.
    send(1'b0, 32'hA5A5A5A5);
    check("steer_out0", 64'(out0_data), 64'hA5A5A5A5);
    send(1'b1, 32'h5A5A5A5A);
    check("steer_out1", 64'(out1_data), 64'h5A5A5A5A);
    in_valid = 1'b0;
    step();

    // Stall on port 1 must not block port 0.
    out1_ready = 1'b0;
    send(1'b1, 32'h12345678);
    send(1'b1, 32'h87654321);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out1_data", 64'(out1_data), 64'h12345678);
    send(1'b0, 32'h00000000);
    check("iso_out0_valid", 64'(out0_valid), 64'd1);
    check("iso_out0_data", 64'(out0_data), 64'd0);
    check("iso_out1_data", 64'(out1_data), 64'h12345678);
    in_valid = 1'b0;
    step();

    // Full throughput on port 0.
    out1_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, DATA_W'(i));
      check("thru_out0_data", 64'(out0_data), 64'(i));
      check("thru_out0_valid", 64'(out0_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Reset while both ports hold stalled words.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 32'hFFFFFFFF);
    send(1'b1, 32'h00000000);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out0_valid", 64'(out0_valid), 64'd0);
    check("midrst_out1_valid", 64'(out1_valid), 64'd0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();

    // Counter wrap: 17 drains on port 0, 3 on port 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send(1'b0, DATA_W'($urandom));
    for (int i = 0; i < 3; i++) send(1'b1, DATA_W'($urandom));
    in_valid = 1'b0;
    step();
`ifdef STREAM_DEMUX_CNT_EN
    check("wrap_cnt0", 64'(cnt0), 64'd1);
    check("wrap_cnt1", 64'(cnt1), 64'd3);
`else
    check("wrap_cnt0", 64'(cnt0), 64'd0);
    check("wrap_cnt1", 64'(cnt1), 64'd0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = DATA_W'($urandom);
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
